phy_tx_sched: RTL and testbench

- Word-level scheduler in front of the PHY transmit path.
- After reset it sequences link bring-up by sending a fixed number of COM training words.
- It then shares the 32-bit transmit word interface between two upstream requesters using round-robin with a bounded burst length.
- It drives the PHY transmit data/valid inputs; its clock is the clk_f domain that feeds byte striping.

---
 rtl/phy_tx_pkg.sv | 19 +
 rtl/tx_rr_pick.sv | 26 ++
 rtl/phy_tx_sched.sv | 113 +++++++++++
 tb/tb_phy_tx_sched.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/phy_tx_pkg.sv
// Shared definitions for the PHY transmit scheduler:
// scheduler state encoding, grant codes and link symbol words.
package phy_tx_pkg;

    typedef enum logic [1:0] {
        ST_TRAIN = 2'd0,
        ST_IDLE  = 2'd1,
        ST_GNT0  = 2'd2,
        ST_GNT1  = 2'd3
    } tx_state_e;

    localparam logic [1:0] GRANT_NONE = 2'b00;
    localparam logic [1:0] GRANT_0    = 2'b01;
    localparam logic [1:0] GRANT_1    = 2'b10;

    localparam logic [31:0] SYM_COM  = 32'hBCBC_BCBC;
    localparam logic [31:0] SYM_IDLE = 32'h7C7C_7C7C;

endpackage

// File: rtl/tx_rr_pick.sv
// Two-way round-robin pick: prefers the requester not served last,
// falls back to the other one, returns a one-hot grant or none.
module tx_rr_pick
    import phy_tx_pkg::*;
(
    input  logic       valid0_i,
    input  logic       valid1_i,
    input  logic       last_grant_i,
    output logic [1:0] grant_o
);

    always_comb begin
        grant_o = GRANT_NONE;
        unique case (1'b1)
            valid0_i & valid1_i:
                grant_o = last_grant_i ? GRANT_0 : GRANT_1;
            valid0_i & ~valid1_i:
                grant_o = GRANT_0;
            ~valid0_i & valid1_i:
                grant_o = GRANT_1;
            default:
                grant_o = GRANT_NONE;
        endcase
    end

endmodule

// File: rtl/phy_tx_sched.sv
// Transmit word scheduler: COM training after reset, then bounded-burst
// round-robin sharing of the PHY word interface between two requesters.
module phy_tx_sched
    import phy_tx_pkg::*;
#(
    parameter int unsigned TS_COUNT  = 16,
    parameter int unsigned MAX_BURST = 4,
    parameter logic [31:0] COM_WORD  = SYM_COM,
    parameter logic [31:0] IDLE_WORD = SYM_IDLE
) (
    input  logic        clk_f,
    input  logic        reset,
    input  logic [31:0] req0_data,
    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [31:0] req1_data,
    input  logic        req1_valid,
    output logic        req1_ready,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic [1:0]  grant,
    output logic        link_up
);

    localparam int TW = $clog2(TS_COUNT + 1);
    localparam int BW = $clog2(MAX_BURST + 1);
    localparam logic [TW-1:0] TS_LAST    = TW'(TS_COUNT - 1);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    tx_state_e     state_q, state_d;
    logic [TW-1:0] train_cnt_q;
    logic [BW-1:0] burst_cnt_q;
    logic          last_q, last_d;
    logic [31:0]   data_q;
    logic          valid_q;
    logic          link_q;
    logic [1:0]    pick;
    logic          xfer;
    logic [31:0]   own_data;

    tx_rr_pick u_pick (
        .valid0_i     (req0_valid),
        .valid1_i     (req1_valid),
        .last_grant_i (last_q),
        .grant_o      (pick)
    );

    assign xfer = ((state_q == ST_GNT0) && req0_valid)
               || ((state_q == ST_GNT1) && req1_valid);
    assign own_data = (state_q == ST_GNT1) ? req1_data : req0_data;

    // Outcome of re-arbitration, used from IDLE and at every burst end.
    always_comb begin
        state_d = ST_IDLE;
        last_d  = last_q;
        unique case (pick)
            GRANT_0: begin
                state_d = ST_GNT0;
                last_d  = 1'b0;
            end
            GRANT_1: begin
                state_d = ST_GNT1;
                last_d  = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_f or posedge reset) begin
        if (reset) begin
            state_q     <= ST_TRAIN;
            train_cnt_q <= '0;
            burst_cnt_q <= '0;
            last_q      <= 1'b1;
            data_q      <= '0;
            valid_q     <= 1'b0;
            link_q      <= 1'b0;
        end else begin
            data_q  <= IDLE_WORD;
            valid_q <= 1'b0;
            if (state_q == ST_TRAIN) begin
                data_q      <= COM_WORD;
                valid_q     <= 1'b1;
                train_cnt_q <= train_cnt_q + 1'b1;
                if (train_cnt_q == TS_LAST) begin
                    state_q <= ST_IDLE;
                end
            end else begin
                link_q <= 1'b1;
                if (xfer) begin
                    data_q  <= own_data;
                    valid_q <= 1'b1;
                end
                if (xfer && burst_cnt_q != BURST_LAST) begin
                    burst_cnt_q <= burst_cnt_q + 1'b1;
                end else begin
                    state_q     <= state_d;
                    last_q      <= last_d;
                    burst_cnt_q <= '0;
                end
            end
        end
    end

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign link_up    = link_q;
    assign req0_ready = (state_q == ST_GNT0);
    assign req1_ready = (state_q == ST_GNT1);
    assign grant      = (state_q == ST_GNT0) ? GRANT_0 :
                        (state_q == ST_GNT1) ? GRANT_1 : GRANT_NONE;

endmodule

// File: tb/tb_phy_tx_sched.sv
// Bench for phy_tx_sched: directed scenarios and random valids
// compared cycle by cycle against a word-level reference model.
module tb_phy_tx_sched;

    localparam int TS = 16;
    localparam int MB = 4;
    localparam logic [31:0] COM  = 32'hBCBC_BCBC;
    localparam logic [31:0] IDLW = 32'h7C7C_7C7C;

    logic        clk_f = 1'b0;
    logic        reset;
    logic [31:0] req0_data, req1_data;
    logic        req0_valid, req1_valid;
    logic        req0_ready, req1_ready;
    logic [31:0] data_out;
    logic        valid_out;
    logic [1:0]  grant;
    logic        link_up;

    int n_chk  = 0;
    int n_pass = 0;
    int n_fail = 0;

    // Requester word streams: next word is base + number already taken.
    logic [31:0] base0, base1;
    int c0, c1;

    // Reference model: words trained, current owner, words taken
    // in this grant, requester served last.
    int m_trained, m_owner, m_taken, m_last;
    logic [31:0] exp_data;
    logic        exp_valid, exp_link;

    always #5 clk_f = ~clk_f;

    phy_tx_sched dut (
        .clk_f      (clk_f),
        .reset      (reset),
        .req0_data  (req0_data),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req1_data  (req1_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .grant      (grant),
        .link_up    (link_up)
    );

    task automatic chk(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] exp_grant();
        if (m_owner == 0) return 2'b01;
        if (m_owner == 1) return 2'b10;
        return 2'b00;
    endfunction

    task automatic model_reset();
        m_trained = 0;
        m_owner   = -1;
        m_taken   = 0;
        m_last    = 1;
        exp_data  = '0;
        exp_valid = 1'b0;
        exp_link  = 1'b0;
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_data"}, data_out, 32'h0);
        chk({tag, "_valid"}, valid_out, 1'b0);
        chk({tag, "_rdy0"}, req0_ready, 1'b0);
        chk({tag, "_rdy1"}, req1_ready, 1'b0);
        chk({tag, "_link"}, link_up, 1'b0);
        chk({tag, "_grant"}, grant, 2'b00);
    endtask

    // One clock: present words, check ready, advance model, check outputs.
    task automatic step(input bit v0, input bit v1);
        logic [31:0] d0, d1;
        bit acc0, acc1, rearb;
        int pref;
        d0 = base0 + 32'(c0);
        d1 = base1 + 32'(c1);
        req0_valid = v0;
        req1_valid = v1;
        req0_data  = d0;
        req1_data  = d1;
        #1;
        chk("ready0", req0_ready, m_owner == 0);
        chk("ready1", req1_ready, m_owner == 1);
        acc0 = v0 && m_owner == 0;
        acc1 = v1 && m_owner == 1;
        if (m_trained < TS) begin
            exp_data  = COM;
            exp_valid = 1'b1;
            m_trained++;
        end else begin
            exp_link  = 1'b1;
            exp_data  = IDLW;
            exp_valid = 1'b0;
            rearb     = 1'b1;
            if (acc0 || acc1) begin
                exp_data  = acc0 ? d0 : d1;
                exp_valid = 1'b1;
                m_taken++;
                rearb = (m_taken == MB);
            end
            if (rearb) begin
                m_taken = 0;
                pref = 1 - m_last;
                if ((pref == 0) ? v0 : v1) m_owner = pref;
                else if ((m_last == 0) ? v0 : v1) m_owner = m_last;
                else m_owner = -1;
                if (m_owner >= 0) m_last = m_owner;
            end
        end
        if (acc0) c0++;
        if (acc1) c1++;
        @(posedge clk_f);
        #1;
        chk("data", data_out, exp_data);
        chk("valid", valid_out, exp_valid);
        chk("link", link_up, exp_link);
        chk("grant", grant, exp_grant());
        @(negedge clk_f);
    endtask

    initial begin
        reset      = 1'b1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_data  = '0;
        req1_data  = '0;
        base0 = 32'h0;
        base1 = 32'h0;
        c0 = 0;
        c1 = 0;
        model_reset();
        #1;
        chk_reset("por");
        @(negedge clk_f);
        reset = 1'b0;

        // Training with no requests, then idle filler.
        repeat (TS + 3) step(0, 0);

        // req0 alone: ten words 0..9 back to back.
        base0 = 32'h0;
        c0 = 0;
        repeat (11) step(1, 0);
        repeat (2) step(0, 0);

        // Both requesting: alternating bursts.
        base0 = 32'hA000_0000;
        base1 = 32'hB000_0000;
        c0 = 0;
        c1 = 0;
        repeat (20) step(1, 1);
        repeat (2) step(0, 0);

        // req1 owns, drops after two words while req0 waits.
        step(0, 1);
        step(0, 1);
        step(0, 1);
        repeat (3) step(1, 0);
        step(1, 1);
        step(0, 1);
        repeat (2) step(0, 0);

        // Reset while the third word of a burst is presented.
        for (int i = 0; i < 20; i++) begin
            if (m_owner >= 0 && m_taken == 2) break;
            step(1, 1);
        end
        chk("burst_sync", m_taken, 2);
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        #2;
        reset = 1'b1;
        #1;
        chk_reset("midrst");
        model_reset();
        @(negedge clk_f);
        reset = 1'b0;

        // Both valid during training, then req0 served first.
        repeat (TS + 6) step(1, 1);

        // Random valids.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
